seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for an 8-digit common-anode seven-segment display on the GPIO peripheral. It accepts a 32-bit hex value plus a per-digit enable mask from the GPIO register interface, double-buffers it so updates land only on frame boundaries (tear-free), and drives one digit at a time with a programmable dwell and anti-ghosting blank interval. Segment encoding is delegated to the existing hex-to-segment decoder.

## Interface
- `DIGITS`, 8: number of digits scanned; the index counter is `$clog2(DIGITS)` bits wide.
- `DIV_W`, 16: width of the slot cycle counter.
- `DIV`, 50000: clock cycles per digit slot, including blanking. Must satisfy `DIV > BLANK_CYC`.
- `BLANK_CYC`, 1000: cycles at the start of each slot during which the display is dark. A value of 0 skips the BLANK state.

- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `wr_en`, in, 1: single-cycle write strobe.
- `wr_data`, in, 32: digit i displays nibble `wr_data[4i+3:4i]`.
- `wr_mask`, in, 8: bit i set enables digit i.
- `an_n`, out, 8: digit select, active-low, registered.
- `seg_out`, out, 8: segments {a..g,dp}, active-low, registered.
- `frame_done`, out, 1: one-cycle pulse at the end of each frame.

## Operation
- Registers:
  - `act_data`/`act_mask`: the active image shown on the display.
  - `pend_data`/`pend_mask`/`pend_valid`: the pending image.
  - `digit` index, slot counter `cnt`, and `state`.
- FSM states are BLANK and ON.
  - BLANK: stay for `BLANK_CYC` cycles, then go to ON with `cnt` cleared.
  - ON: stay for `DIV-BLANK_CYC` cycles, then go to BLANK. If `BLANK_CYC`=0, go to ON again.
  - `digit` increments at the end of ON and wraps from `DIGITS-1` to 0.
- Frame boundary is the last ON cycle of digit `DIGITS-1`. In that cycle:
  - `frame_done` (next-cycle registered pulse) is raised.
  - If `pend_valid` is set, copy pending to active and clear `pend_valid`.
- Writes:
  - `wr_en` outside a boundary cycle loads the pending image and sets `pend_valid`. A later write in the same frame overwrites it (last wins).
  - `wr_en` in the boundary cycle bypasses pending and goes straight to active. `pend_valid` clears, and the new frame shows the write.
- Next-state of outputs:
  - When state is ON and `act_mask[digit]`=1: `an_n` = ~(1<<digit), and `seg_out` = decoder(`act_data` nibble, en=1).
  - Otherwise: `an_n`=8'hFF and `seg_out`=8'hFF.
  - A masked digit still consumes its full slot, so frame period stays constant.
- Reset values:
  - `an_n`=8'hFF, `seg_out`=8'hFF, `frame_done`=0.
  - `act_*`=0 (all digits off), `pend_valid`=0.
  - `digit`=0, `cnt`=0, `state`=BLANK (ON if `BLANK_CYC`=0).

## Timing
- Outputs lag the FSM by exactly one cycle, because of the registered output stage.
- Frame period is `DIGITS*DIV` cycles. `frame_done` repeats with that period.
- After `rst_n` deasserts, the first digit-0 ON pin activity appears at cycle `BLANK_CYC+1`.
- A write becomes visible at most `DIGITS*DIV+1` cycles after `wr_en`.
- Reset asserted mid-slot forces all outputs to reset values immediately (asynchronous). Operation restarts cleanly on the first edge after release.
- `wr_en` during reset is ignored.

## Structure
- Package `seg_scan_pkg` holds:
  - the `SEG_BLANK`=8'hFF and `AN_OFF`=8'hFF constants;
  - the state enum {BLANK, ON}.
- Sub-module: instantiate the existing `segment_hex` decoder once, on the muxed nibble selected by `digit`, with `en`=`act_mask[digit]`. Its output feeds the `seg_out` register.

## Test plan
All scenarios use `DIV`=4 and `BLANK_CYC`=1.
- Reset: hold `rst_n`=0 for 5 cycles and release. Required: `an_n`=8'hFF, `seg_out`=8'hFF and `frame_done`=0 throughout, and all digits stay dark for the whole first frame (mask=0).
- Write 32'h0000_00F5 with mask 8'h03 in frame 0. Required from frame 1 on:
  - digit 0: `an_n`=8'hFE with `seg_out`=8'h49 for 3 cycles, then 1 dark cycle;
  - digit 1: `an_n`=8'hFD with `seg_out`=8'h71;
  - digits 2–7: dark;
  - `frame_done` every 32 cycles.
- Mid-frame update: with 32'h0 and mask 8'h01 active, write 32'h1 during digit 3. Required: digit 0 keeps `seg_out`=8'h03 until `frame_done`, then shows 8'h9F.
- Boundary collision: assert `wr_en` (32'h8, mask 8'h01) exactly in the boundary cycle. Required: the very next frame shows 8'h01 on digit 0, and `pend_valid`=0.
- Last-wins: two writes (32'h2, then 32'h3, mask 8'h01) in one frame. Required: the next frame shows 8'h0D, and 8'h25 never appears.
- Async reset mid-ON of digit 1. Required: `an_n`/`seg_out` go to 8'hFF in the same cycle without a clock edge, and after release the display is dark with mask=0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants and state type for the seven-segment scan controller
package seg_scan_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_e;

endpackage

// File: rtl/segment_hex.sv
// rtl/segment_hex.sv - hex nibble to active-low seven-segment pattern {a..g,dp}
module segment_hex
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  input  logic       en_i,
  output logic [7:0] seg_o
);

  logic [7:0] pattern;

  // bit 7 = a ... bit 1 = g, bit 0 = dp; a 0 lights the segment
  always_comb begin
    pattern = SEG_BLANK;
    case (hex_i)
      4'h0: pattern = 8'h03;
      4'h1: pattern = 8'h9F;
      4'h2: pattern = 8'h25;
      4'h3: pattern = 8'h0D;
      4'h4: pattern = 8'h99;
      4'h5: pattern = 8'h49;
      4'h6: pattern = 8'h41;
      4'h7: pattern = 8'h1F;
      4'h8: pattern = 8'h01;
      4'h9: pattern = 8'h09;
      4'hA: pattern = 8'h11;
      4'hB: pattern = 8'hC1;
      4'hC: pattern = 8'h63;
      4'hD: pattern = 8'h85;
      4'hE: pattern = 8'h61;
      4'hF: pattern = 8'h71;
      default: pattern = SEG_BLANK;
    endcase
  end

  assign seg_o = en_i ? pattern : SEG_BLANK;

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - tear-free multiplexed scan of an 8-digit common-anode display
// with per-digit enable, programmable dwell and anti-ghosting blank interval.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int DIV_W     = 16,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_mask,
  output logic [DIGITS-1:0]     an_n,
  output logic [7:0]            seg_out,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] ON_LAST    = DIV_W'(DIV - BLANK_CYC - 1);
  localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  // With no blank interval every slot starts directly in ON.
  localparam scan_state_e SLOT_START = (BLANK_CYC > 0) ? BLANK : ON;

  scan_state_e            state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       digit_q, digit_d;
  logic [4*DIGITS-1:0]    act_data_q, act_data_d;
  logic [DIGITS-1:0]      act_mask_q, act_mask_d;
  logic [4*DIGITS-1:0]    pend_data_q, pend_data_d;
  logic [DIGITS-1:0]      pend_mask_q, pend_mask_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic [7:0]             seg_q, seg_d;
  logic                   frame_done_q;

  logic       on_last;
  logic       boundary;
  logic [3:0] cur_nibble;
  logic       cur_en;
  logic [7:0] dec_seg;

  assign on_last  = (state_q == ON) && (cnt_q == ON_LAST);
  assign boundary = on_last && (digit_q == LAST_DIGIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON: begin
        if (on_last) begin
          state_d = SLOT_START;
          cnt_d   = '0;
          digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + 1'b1;
        end
      end
      default: begin
        state_d = SLOT_START;
        cnt_d   = '0;
      end
    endcase
  end

  // A write landing on the boundary cycle goes straight to the active image so
  // the new frame shows it; otherwise it parks in pending until the next boundary.
  always_comb begin
    act_data_d   = act_data_q;
    act_mask_d   = act_mask_q;
    pend_data_d  = pend_data_q;
    pend_mask_d  = pend_mask_q;
    pend_valid_d = pend_valid_q;
    if (wr_en && boundary) begin
      act_data_d   = wr_data;
      act_mask_d   = wr_mask;
      pend_valid_d = 1'b0;
    end else if (wr_en) begin
      pend_data_d  = wr_data;
      pend_mask_d  = wr_mask;
      pend_valid_d = 1'b1;
    end else if (boundary && pend_valid_q) begin
      act_data_d   = pend_data_q;
      act_mask_d   = pend_mask_q;
      pend_valid_d = 1'b0;
    end
  end

  assign cur_nibble = act_data_q[{digit_q, 2'b00} +: 4];
  assign cur_en     = act_mask_q[digit_q];

  segment_hex u_segment_hex (
    .hex_i (cur_nibble),
    .en_i  (cur_en),
    .seg_o (dec_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if ((state_q == ON) && cur_en) begin
      an_d  = ~(DIGITS'(1) << digit_q);
      seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SLOT_START;
      cnt_q        <= '0;
      digit_q      <= '0;
      act_data_q   <= '0;
      act_mask_q   <= '0;
      pend_data_q  <= '0;
      pend_mask_q  <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      act_data_q   <= act_data_d;
      act_mask_q   <= act_mask_d;
      pend_data_q  <= pend_data_d;
      pend_mask_q  <= pend_mask_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= boundary;
    end
  end

  assign an_n       = an_q;
  assign seg_out    = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl against a frame-position reference model
module tb_seg_scan_ctrl;

  localparam int DIGITS    = 8;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_mask;
  logic [7:0]  an_n;
  logic [7:0]  seg_out;
  logic        frame_done;

  seg_scan_ctrl #(
    .DIGITS    (DIGITS),
    .DIV_W     (16),
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .an_n       (an_n),
    .seg_out    (seg_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;

  // Lit segments per hex digit, written as segment letters.
  string seg_lit [0:15] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [7:0] seg_ref(input logic [3:0] h);
    string      s;
    logic [7:0] r;
    r = 8'hFF;
    s = seg_lit[h];
    for (int i = 0; i < s.len(); i++) r[7 - (int'(s[i]) - 97)] = 1'b0;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, got, want, $time);
  endtask

  // Reference model: display state is a pure function of cycle position in the frame.
  int          mk;
  logic [31:0] m_act_d, m_pend_d;
  logic [7:0]  m_act_m, m_pend_m;
  bit          m_pv;

  always @(posedge clk or negedge rst_n) begin : model
    int   pos, dg;
    bit   lit_on, bnd;
    exp_t e;
    if (!rst_n) begin
      mk = 0; m_act_d = 0; m_act_m = 0; m_pend_d = 0; m_pend_m = 0; m_pv = 0;
      exp_q.delete();
    end else begin
      pos    = mk % FRAME;
      dg     = pos / DIV;
      lit_on = (pos % DIV) >= BLANK_CYC;
      bnd    = (pos == FRAME - 1);
      e.fd   = bnd;
      if (lit_on && m_act_m[dg]) begin
        e.an  = ~(8'd1 << dg);
        e.seg = seg_ref(m_act_d[dg*4 +: 4]);
      end else begin
        e.an  = 8'hFF;
        e.seg = 8'hFF;
      end
      exp_q.push_back(e);
      if (wr_en && bnd) begin
        m_act_d = wr_data; m_act_m = wr_mask; m_pv = 0;
      end else if (wr_en) begin
        m_pend_d = wr_data; m_pend_m = wr_mask; m_pv = 1;
      end else if (bnd && m_pv) begin
        m_act_d = m_pend_d; m_act_m = m_pend_m; m_pv = 0;
      end
      mk++;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      check("reset_an", an_n, 8'hFF);
      check("reset_seg", seg_out, 8'hFF);
      check("reset_fd", {7'd0, frame_done}, 8'h00);
    end else if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL scoreboard_empty: got no expectation required one at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("an_n", an_n, e.an);
      check("seg_out", seg_out, e.seg);
      check("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while ((mk % FRAME) != p && n < 2 * FRAME) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if ((mk % FRAME) == p) passes++;
    else $display("FAIL wait_pos: got position %0d required %0d", mk % FRAME, p);
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] m);
    wr_en   = 1'b1;
    wr_data = d;
    wr_mask = m;
    @(negedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  initial begin
    wr_en   = 1'b0;
    wr_data = '0;
    wr_mask = '0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;

    wait_pos(10);
    write(32'h0000_00F5, 8'h03);
    run(3 * FRAME);

    wait_pos(3);
    write(32'h0, 8'h01);
    run(FRAME + 4);
    wait_pos(13);
    write(32'h1, 8'h01);
    run(2 * FRAME);

    wait_pos(31);
    write(32'h8, 8'h01);
    run(2 * FRAME);

    wait_pos(5);
    write(32'h2, 8'h01);
    wait_pos(20);
    write(32'h3, 8'h01);
    run(2 * FRAME);

    write(32'h0000_00A5, 8'h03);
    run(FRAME + 2);
    wait_pos(6);
    rst_n = 1'b0;
    #1;
    check("async_an", an_n, 8'hFF);
    check("async_seg", seg_out, 8'hFF);
    check("async_fd", {7'd0, frame_done}, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    run(FRAME + 2);

    repeat (30) begin
      run($urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) wait_pos(FRAME - 1);
      write($urandom, 8'($urandom));
    end
    run(2 * FRAME + 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
